// File: rtl/signed_divider_seq.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per cycle, sign fix-up at the end, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring-division step per cycle, DIVIDEND_W cycles
// FIX   | apply result signs and register outputs
// DONE  | result presented, held until out_ready
module signed_divider_seq #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    prem_q, prem_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;

    logic                  accept;
    logic                  dvd_neg, dvs_neg;
    logic                  dvs_zero, ovf_case;
    logic [DIVIDEND_W-1:0] dvd_abs;
    logic [DIVISOR_W-1:0]  dvs_abs;
    logic [DIVISOR_W+1:0]  prem_sh;
    logic [DIVISOR_W+1:0]  trial;
    logic                  trial_ge;

    assign in_ready    = (state_q == IDLE) && rst_n;
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    assign accept   = in_valid && in_ready;
    assign dvd_neg  = dividend[DIVIDEND_W-1];
    assign dvs_neg  = divisor[DIVISOR_W-1];
    assign dvd_abs  = dvd_neg ? -dividend : dividend;
    assign dvs_abs  = dvs_neg ? -divisor : divisor;
    assign dvs_zero = (divisor == '0);
    assign ovf_case = (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor == '1);

    // Shifted partial remainder is one bit wider than the stored one; the extra
    // MSB of the trial difference is the borrow that decides restore vs keep.
    assign prem_sh  = {prem_q, dvd_q[DIVIDEND_W-1]};
    assign trial    = prem_sh - {2'b00, dvs_q};
    assign trial_ge = ~trial[DIVISOR_W+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d  = dvd_abs;
                    dvs_d  = dvs_abs;
                    prem_d = '0;
                    cnt_d  = CNT_W'(DIVIDEND_W);
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (dvs_zero) begin
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (ovf_case) begin
                        quot_d  = dividend;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = trial_ge ? trial[DIVISOR_W:0] : prem_sh[DIVISOR_W:0];
                dvd_d  = {dvd_q[DIVIDEND_W-2:0], trial_ge};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // |remainder| < |divisor|, so the low DIVISOR_W bits hold it exactly.
                quot_d  = qneg_q ? -dvd_q : dvd_q;
                rem_d   = rneg_q ? -prem_q[DIVISOR_W-1:0] : prem_q[DIVISOR_W-1:0];
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Self-checking bench for signed_divider_seq: directed corner cases, backpressure,
// mid-operation reset, then a randomized handshake sweep against a / and % model.
module tb_signed_divider_seq;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int N_RND = 1500;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          in_ready, out_valid, div_by_zero, overflow;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    int errors = 0;
    int checks = 0;

    signed_divider_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer / and % with the two exceptional cases.
    function automatic void model(input logic [DW-1:0] x, input logic [VW-1:0] y,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output logic z, output logic o);
        int a, b;
        a = int'($signed(x));
        b = int'($signed(y));
        z = 1'b0;
        o = 1'b0;
        if (b == 0) begin
            q = '1; r = '0; z = 1'b1;
        end else if (a == -(1 << (DW-1)) && b == -1) begin
            q = DW'(-a); r = '0; o = 1'b1;
        end else begin
            q = DW'(a / b); r = VW'(a % b);
        end
    endfunction

    // Latency is counted in clock edges from the accept edge inclusive up to the
    // edge after which out_valid is first seen: 1 for exceptions, DW+2 otherwise.
    task automatic do_op(input logic [DW-1:0] x, input logic [VW-1:0] y,
                         input int hold, input int exp_lat, input string tag);
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic ez, eo;
        int lat, n;
        model(x, y, eq, er, ez, eo);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        dividend = x;
        divisor  = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
        chk({tag, "_remainder"}, 64'(remainder), 64'(er));
        chk({tag, "_flags"}, 64'({div_by_zero, overflow}), 64'({ez, eo}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold"}, 64'({out_valid, in_ready, quotient, remainder}),
                64'({1'b1, 1'b0, eq, er}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        logic [DW+VW+1:0] exp_q[$];
        logic [DW+VW+1:0] e;
        logic [DW-1:0] eq, rx;
        logic [VW-1:0] er, ry;
        logic ez, eo, acc, ret, seen;
        int issued, retired, cyc, sel;

        #23;
        chk("reset_outputs", 64'({in_ready, out_valid, quotient, remainder, div_by_zero, overflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        do_op(DW'(100),    VW'(7),    0, DW+2, "p100_p7");
        do_op(DW'(-100),   VW'(7),    0, DW+2, "m100_p7");
        do_op(DW'(100),    VW'(-7),   0, DW+2, "p100_m7");
        do_op(DW'(-100),   VW'(-7),   0, DW+2, "m100_m7");
        do_op(DW'(5),      VW'(0),    0, 1,    "div_zero");
        do_op(DW'(-32768), VW'(-1),   0, 1,    "ovf");
        do_op(DW'(-32768), VW'(-128), 0, DW+2, "min_min");
        do_op(DW'(1000),   VW'(3),    10, DW+2, "backpressure");
        do_op(DW'(32767),  VW'(-128), 0, DW+2, "max_mdiv");

        // Reset in the middle of CALC must discard the operation silently.
        @(negedge clk);
        dividend = DW'(1234);
        divisor  = VW'(5);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 64'({in_ready, out_valid, quotient, remainder, div_by_zero, overflow}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midreset_no_valid", 64'(seen), 64'(0));
        do_op(DW'(7), VW'(2), 0, DW+2, "after_reset");

        // Randomized sweep with random in_valid gaps and out_ready backpressure.
        issued = 0;
        retired = 0;
        cyc = 0;
        while (retired < N_RND && cyc < 90000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_result", 64'({quotient, remainder, div_by_zero, overflow}), 64'(e));
                end
                retired++;
            end
            if (acc) begin
                model(dividend, divisor, eq, er, ez, eo);
                exp_q.push_back({eq, er, ez, eo});
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) in_valid = 1'b0;
            if (!in_valid && issued < N_RND && $urandom_range(3) != 0) begin
                rx = DW'($urandom);
                ry = VW'($urandom);
                sel = int'($urandom_range(15));
                if (sel == 0) ry = '0;
                if (sel == 1) begin rx = {1'b1, {(DW-1){1'b0}}}; ry = '1; end
                if (sel == 2) ry = '1;
                if (sel == 3) rx = {1'b1, {(DW-1){1'b0}}};
                if (sel == 4) ry = {1'b1, {(VW-1){1'b0}}};
                dividend = rx;
                divisor  = ry;
                in_valid = 1'b1;
                issued++;
            end
            out_ready = ($urandom_range(3) != 0);
        end
        chk("rnd_retired", 64'(retired), 64'(N_RND));
        chk("rnd_leftover", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
